// File: rtl/mux_share_arbiter.sv
// Round-robin share of one WIDTH-bit 2:1 operand mux between sources A and B,
// with a burst limit and a single-entry registered output stage.
module mux_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int BURST = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_src,
  input  logic             y_ready,
  output logic             dbg_state
);

  // Handshake rule: a beat moves from a source when its valid and ready are
  // both high at a rising edge; the held beat leaves when y_valid & y_ready.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [2:0] BURST_C = 3'(BURST);
  localparam logic [2:0] CNT_MAX = 3'd7;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_src_q, y_src_d;
  logic             owner_q, owner_d;
  logic [2:0]       cnt_q, cnt_d;

  logic slot_free;
  logic choice;
  logic xfer;

  assign y_valid   = (state_q == FULL);
  assign y_data    = y_data_q;
  assign y_src     = y_src_q;
  assign dbg_state = state_q;

  always_comb begin
    choice = owner_q;
    if (a_valid && !b_valid) begin
      choice = 1'b0;
    end else if (b_valid && !a_valid) begin
      choice = 1'b1;
    end else if (a_valid && b_valid) begin
      choice = (cnt_q < BURST_C) ? owner_q : ~owner_q;
    end
  end

  // Readys are gated by rst_n so nothing is accepted during reset.
  assign slot_free = !y_valid || y_ready;
  assign xfer      = rst_n && slot_free && (a_valid || b_valid);
  assign sel       = choice;
  assign a_ready   = rst_n && slot_free && a_valid && !choice;
  assign b_ready   = rst_n && slot_free && b_valid && choice;

  always_comb begin
    state_d  = state_q;
    y_data_d = y_data_q;
    y_src_d  = y_src_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL: begin
        if (y_ready) state_d = xfer ? FULL : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (xfer) begin
      y_data_d = choice ? b_data : a_data;
      y_src_d  = choice;
      if (choice == owner_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 3'd1;
      end else begin
        owner_d = choice;
        cnt_d   = 3'd1;
      end
    end
  end

  // Reset leaves B as owner with a spent burst so A wins the first contest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      y_data_q <= '0;
      y_src_q  <= 1'b0;
      owner_q  <= 1'b1;
      cnt_q    <= BURST_C;
    end else begin
      state_q  <= state_d;
      y_data_q <= y_data_d;
      y_src_q  <= y_src_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for mux_share_arbiter: reset, round-robin bursts, lone source,
// backpressure, burst break and mid-operation reset.
module tb_mux_share_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_valid, b_valid, y_ready;
  logic [3:0] a_data, b_data;
  logic       a_ready, b_ready, sel, y_valid, y_src, dbg_state;
  logic [3:0] y_data;

  int checks = 0;
  int errors = 0;

  mux_share_arbiter #(.WIDTH(4), .BURST(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .sel       (sel),
    .y_valid   (y_valid),
    .y_data    (y_data),
    .y_src     (y_src),
    .y_ready   (y_ready),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag, input logic v, input logic [3:0] d, input logic s);
    chk({tag, ".y_valid"}, 32'(y_valid), 32'(v));
    chk({tag, ".y_data"},  32'(y_data),  32'(d));
    chk({tag, ".y_src"},   32'(y_src),   32'(s));
  endtask

  task automatic chk_rdy(input string tag, input logic s, input logic ar, input logic br);
    chk({tag, ".sel"},     32'(sel),     32'(s));
    chk({tag, ".a_ready"}, 32'(a_ready), 32'(ar));
    chk({tag, ".b_ready"}, 32'(b_ready), 32'(br));
  endtask

  logic       exp_src2 [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [3:0] exp_dat2 [6] = '{4'h3, 4'h3, 4'hC, 4'hC, 4'h3, 4'h3};

  initial begin
    // 1: reset with everything requesting
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_data = 4'h3; b_data = 4'hC; y_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_y("rst", 1'b0, 4'h0, 1'b0);
      chk("rst.a_ready", 32'(a_ready), 32'd0);
      chk("rst.b_ready", 32'(b_ready), 32'd0);
      chk("rst.state",   32'(dbg_state), 32'd0);
    end

    // 2: contested round-robin, first grant to A
    rst_n = 1'b1;
    #1;
    chk_rdy("rr.first", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_y($sformatf("rr%0d", i), 1'b1, exp_dat2[i], exp_src2[i]);
    end

    // 3: B alone for five beats, then A joins and wins (B burst spent)
    a_valid = 1'b0; b_data = 4'h9;
    #1;
    chk_rdy("lone_b.grant", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_y($sformatf("lone_b%0d", i), 1'b1, 4'h9, 1'b1);
    end
    a_valid = 1'b1;
    #1;
    chk_rdy("join_a", 1'b0, 1'b1, 1'b0);
    tick();
    chk_y("join_a.beat", 1'b1, 4'h3, 1'b0);

    // 4: backpressure holding 5 (A owns, count 1 -> A again)
    a_data = 4'h5; b_data = 4'hC;
    tick();
    chk_y("bp.load", 1'b1, 4'h5, 1'b0);
    y_ready = 1'b0;
    #1;
    chk_rdy("bp.stall0", sel, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_y($sformatf("bp.hold%0d", i), 1'b1, 4'h5, 1'b0);
      chk($sformatf("bp.a_ready%0d", i), 32'(a_ready), 32'd0);
      chk($sformatf("bp.b_ready%0d", i), 32'(b_ready), 32'd0);
    end
    y_ready = 1'b1;
    #1;
    chk_rdy("bp.release", 1'b1, 1'b0, 1'b1);
    tick();
    chk_y("bp.next", 1'b1, 4'hC, 1'b1);

    // 5: burst break
    tick();
    chk_y("brk.b2", 1'b1, 4'hC, 1'b1);
    tick();
    chk_y("brk.a1", 1'b1, 4'h5, 1'b0);
    a_valid = 1'b0;
    #1;
    chk_rdy("brk.drop", 1'b1, 1'b0, 1'b1);
    tick();
    chk_y("brk.b_new", 1'b1, 4'hC, 1'b1);
    a_valid = 1'b1;
    #1;
    chk_rdy("brk.rereq", 1'b1, 1'b0, 1'b1);
    tick();
    chk_y("brk.b_keep", 1'b1, 4'hC, 1'b1);
    tick();
    chk_y("brk.a_back", 1'b1, 4'h5, 1'b0);

    // 6: reset while a beat is held
    y_ready = 1'b0;
    tick();
    chk_y("mid.held", 1'b1, 4'h5, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid.a_ready", 32'(a_ready), 32'd0);
    chk("mid.b_ready", 32'(b_ready), 32'd0);
    tick();
    chk_y("mid.rst", 1'b0, 4'h0, 1'b0);
    rst_n = 1'b1; y_ready = 1'b1;
    #1;
    chk_rdy("mid.first", 1'b0, 1'b1, 1'b0);
    tick();
    chk_y("mid.beat", 1'b1, 4'h5, 1'b0);

    // idle drain: FULL -> EMPTY with no requester
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    chk("idle.y_valid", 32'(y_valid), 32'd0);
    chk("idle.state",   32'(dbg_state), 32'd0);
    b_valid = 1'b1; b_data = 4'hA;
    tick();
    chk_y("idle.b", 1'b1, 4'hA, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
